fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2: source operands per ID instruction, legal range 1..4.
REQ-002 Parameter REG_ADDR_W, default 5: register address width.
REQ-003 Parameter LOAD_LAT, default 1: load data availability. 1 means data is forwardable from MEM. 2 means data is forwardable from WB only.
REQ-004 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 id_valid  in  1  the ID stage holds a real instruction.
REQ-008 id_rs  in  NUM_SRC*REG_ADDR_W  source register addresses; operand k occupies slice k.
REQ-009 id_rd  in  REG_ADDR_W  destination address of the ID instruction.
REQ-010 id_we  in  1  the ID instruction writes id_rd.
REQ-011 id_is_load  in  1  the ID instruction is a load.
REQ-012 hold  in  1  global pipeline freeze; no stage advances.
REQ-013 flush  in  1  kill the ID instruction; it is not admitted to EX.
REQ-014 fwd_sel  out  NUM_SRC*2  per-operand source select: 00 regfile, 01 WB, 10 MEM, 11 EX.
REQ-015 stall_id  out  1  ID must hold; a bubble enters EX.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with stall_id=1.

Function
REQ-017 The block SHALL track three stage entries (EX, MEM, WB), each holding {valid, rd, we, is_load}.
REQ-018 When hold=0, the block SHALL shift entries EX->MEM->WB on each edge.
REQ-019 On each such shift, EX SHALL be loaded from ID when id_valid=1, stall_id=0 and flush=0; otherwise EX SHALL be loaded with valid=0 (bubble).
REQ-020 When hold=1, all stage entries and stall_cnt SHALL keep their values.
REQ-021 fwd_sel and stall_id SHALL be combinational from the current stage entries and the ID inputs, with zero-cycle latency.
REQ-022 A stage matches operand k when valid=1, we=1, rd equals slice k, and slice k is nonzero.
REQ-023 An operand whose address is 0 SHALL always select 00.
REQ-024 Operand priority SHALL be EX > MEM > WB > regfile; the youngest match wins.
REQ-025 An EX match whose entry has is_load=1 SHALL NOT select 11; it raises a load-use hazard.
REQ-026 When LOAD_LAT=2, a MEM match whose entry has is_load=1 SHALL NOT select 10; it raises a load-use hazard.
REQ-027 stall_id SHALL be 1 when id_valid=1, flush=0, and any operand has a load-use hazard.
REQ-028 During a load-use stall, fwd_sel is don't-care.
REQ-029 stall_id SHALL clear automatically once the load advances to a forwardable stage.
REQ-030 Resulting stall length: 1 cycle for LOAD_LAT=1; 2 cycles for LOAD_LAT=2 when the load is immediately followed by its user.
REQ-031 flush=1 SHALL force stall_id=0 in the same cycle.
REQ-032 stall_cnt SHALL increment on each edge where stall_id=1 and hold=0, and SHALL saturate at all-ones.
REQ-033 Simultaneous hold=1 and stall_id=1 SHALL neither advance any stage nor count.

Reset
REQ-034 When rst_n=0, all stage valid bits and stall_cnt SHALL be cleared immediately, without waiting for a clock edge.
REQ-035 While in reset, outputs SHALL be fwd_sel=0 and stall_id=0.
REQ-036 Reset asserted mid-stall SHALL discard the pending hazard.

Configuration
REQ-037 With FWD_WB_BYPASS_EN defined, WB matches SHALL select 01.
REQ-038 With FWD_WB_BYPASS_EN undefined, WB matches SHALL be ignored and such operands select 00; the register file is then write-before-read. Select code 01 is never produced.

Structure
REQ-039 A shared package fwd_pkg SHALL hold the select encodings (FWD_RF, FWD_WB, FWD_MEM, FWD_EX) and the stage-entry struct typedef.
REQ-040 A sub-module fwd_match SHALL compare one operand against the three stage entries and return {sel, hazard}.
REQ-041 fwd_match SHALL be instantiated NUM_SRC times.

Verification
REQ-042 Reset, then ID rs={2,3} with no prior writes -> fwd_sel=0000, stall_id=0.
REQ-043 Issue ALU with rd=3, then ID rs={2,3} -> operand1 selects 11 and operand0 selects 00.
REQ-044 Issue ALU with rd=3, then ALU with rd=3, then ID rs={3,3} -> both operands select 11 (EX wins over MEM).
REQ-045 Issue load with rd=5, then ID rs={5,0} -> stall_id=1 for 1 cycle, stall_cnt=1, then operand0 selects 10.
REQ-046 Repeat REQ-045 with LOAD_LAT=2 -> 2 stall cycles, then operand0 selects 01 (macro defined).
REQ-047 Raise hold during a stall, then flush, then pulse rst_n low mid-stall -> no count while held, stall_id=0 on flush, all valid bits clear asynchronously on reset.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared select encodings and pipeline stage-entry type for fwd_hazard_unit.
// Optional WB bypass is enabled with the FWD_WB_BYPASS_EN macro.
package fwd_pkg;

  // Widest register address a stage entry can hold; narrower addresses are zero-extended.
  localparam int unsigned RegAddrWMax = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_EX  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic [RegAddrWMax-1:0] rd;
    logic                   we;
    logic                   is_load;
  } stage_t;

  function automatic logic stage_hit(input stage_t e, input logic [RegAddrWMax-1:0] rs);
    return e.valid && e.we && (e.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one ID source operand against the EX/MEM/WB entries and picks its bypass source.
// WB bypass is produced only when FWD_WB_BYPASS_EN is defined.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  stage_t                i_ex,
  input  stage_t                i_mem,
  input  stage_t                i_wb,
  output fwd_sel_e              o_sel,
  output logic                  o_hazard
);

  logic [RegAddrWMax-1:0] w_rs;
  logic                   w_ex_hit;
  logic                   w_mem_hit;
  logic                   w_wb_hit;
  logic                   w_unused_wb_load;

  assign w_rs      = RegAddrWMax'(i_rs);
  assign w_ex_hit  = stage_hit(i_ex, w_rs);
  assign w_mem_hit = stage_hit(i_mem, w_rs);
  assign w_wb_hit  = stage_hit(i_wb, w_rs);

  // Load data in WB is always available, so its is_load flag never matters.
  assign w_unused_wb_load = i_wb.is_load;

  always_comb begin
    o_sel    = FWD_RF;
    o_hazard = 1'b0;
    if (w_ex_hit) begin
      if (i_ex.is_load) begin
        o_hazard = 1'b1;
      end else begin
        o_sel = FWD_EX;
      end
    end else if (w_mem_hit) begin
      if ((LOAD_LAT == 2) && i_mem.is_load) begin
        o_hazard = 1'b1;
      end else begin
        o_sel = FWD_MEM;
      end
    end else if (w_wb_hit) begin
`ifdef FWD_WB_BYPASS_EN
      o_sel = FWD_WB;
`else
      // Write-before-read register file already returns the WB value.
      o_sel = FWD_RF;
`endif
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall unit tracking EX/MEM/WB destination entries.
// Define FWD_WB_BYPASS_EN to enable forwarding from WB (select 01).
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0]         i_id_rd,
  input  logic                          i_id_we,
  input  logic                          i_id_is_load,
  input  logic                          i_hold,
  input  logic                          i_flush,
  output logic [NUM_SRC*2-1:0]          o_fwd_sel,
  output logic                          o_stall_id,
  output logic [CNT_W-1:0]              o_stall_cnt
);

  stage_t             r_ex;
  stage_t             r_mem;
  stage_t             r_wb;
  logic [CNT_W-1:0]   r_stall_cnt;

  stage_t             w_id_entry;
  stage_t             w_ex_next;
  logic [NUM_SRC-1:0] w_hazard;
  logic               w_stall;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_sel_e w_sel;

    fwd_match #(
      .REG_ADDR_W(REG_ADDR_W),
      .LOAD_LAT  (LOAD_LAT)
    ) u_match (
      .i_rs    (i_id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .i_ex    (r_ex),
      .i_mem   (r_mem),
      .i_wb    (r_wb),
      .o_sel   (w_sel),
      .o_hazard(w_hazard[k])
    );

    assign o_fwd_sel[2*k +: 2] = w_sel;
  end

  assign w_stall     = i_id_valid && !i_flush && (|w_hazard);
  assign o_stall_id  = w_stall;
  assign o_stall_cnt = r_stall_cnt;

  always_comb begin
    w_id_entry         = '0;
    w_id_entry.valid   = 1'b1;
    w_id_entry.rd      = RegAddrWMax'(i_id_rd);
    w_id_entry.we      = i_id_we;
    w_id_entry.is_load = i_id_is_load;

    // Stalled or flushed instructions leave a bubble behind in EX.
    w_ex_next = '0;
    if (i_id_valid && !w_stall && !i_flush) begin
      w_ex_next = w_id_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else if (!i_hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_ex_next;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=1 / LOAD_LAT=2 with a 2-bit counter) share stimulus.
// Expected outputs are hand-derived per step and queued when the step is driven.
module tb_fwd_hazard_unit;

`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] WbSel = 2'b01;
`else
  localparam logic [1:0] WbSel = 2'b00;
`endif
  localparam logic [3:0] SelWb0 = {2'b00, WbSel};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [9:0] id_rs = '0;
  logic [4:0] id_rd = '0;
  logic       id_we = 1'b0;
  logic       id_is_load = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;

  logic [3:0]  sel_a;
  logic        stall_a;
  logic [15:0] cnt_a;
  logic [3:0]  sel_b;
  logic        stall_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  fwd_hazard_unit dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_id_valid  (id_valid),
    .i_id_rs     (id_rs),
    .i_id_rd     (id_rd),
    .i_id_we     (id_we),
    .i_id_is_load(id_is_load),
    .i_hold      (hold),
    .i_flush     (flush),
    .o_fwd_sel   (sel_a),
    .o_stall_id  (stall_a),
    .o_stall_cnt (cnt_a)
  );

  fwd_hazard_unit #(
    .NUM_SRC   (2),
    .REG_ADDR_W(5),
    .LOAD_LAT  (2),
    .CNT_W     (2)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_id_valid  (id_valid),
    .i_id_rs     (id_rs),
    .i_id_rd     (id_rd),
    .i_id_we     (id_we),
    .i_id_is_load(id_is_load),
    .i_hold      (hold),
    .i_flush     (flush),
    .o_fwd_sel   (sel_b),
    .o_stall_id  (stall_b),
    .o_stall_cnt (cnt_b)
  );

  typedef struct {
    string      tag;
    logic [3:0] sel_a;
    bit         chk_a;
    logic       stall_a;
    int         cnt_a;
    logic [3:0] sel_b;
    bit         chk_b;
    logic       stall_b;
    int         cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag,
                          input logic [3:0] sa, input bit ka, input logic sta, input int ca,
                          input logic [3:0] sb, input bit kb, input logic stb, input int cb);
    exp_t e;
    e.tag = tag;
    e.sel_a = sa; e.chk_a = ka; e.stall_a = sta; e.cnt_a = ca;
    e.sel_b = sb; e.chk_b = kb; e.stall_b = stb; e.cnt_b = cb;
    exp_q.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (e.chk_a) check_eq({e.tag, ".sel_a"}, 32'(sel_a), 32'(e.sel_a));
      check_eq({e.tag, ".stall_a"}, 32'(stall_a), 32'(e.stall_a));
      check_eq({e.tag, ".cnt_a"}, 32'(cnt_a), 32'(e.cnt_a));
      if (e.chk_b) check_eq({e.tag, ".sel_b"}, 32'(sel_b), 32'(e.sel_b));
      check_eq({e.tag, ".stall_b"}, 32'(stall_b), 32'(e.stall_b));
      check_eq({e.tag, ".cnt_b"}, 32'(cnt_b), 32'(e.cnt_b));
    end
  endtask

  task automatic drive(input logic v, input int rs0, input int rs1, input int rd,
                       input logic we, input logic ld, input logic h, input logic f);
    id_valid   = v;
    id_rs      = {5'(rs1), 5'(rs0)};
    id_rd      = 5'(rd);
    id_we      = we;
    id_is_load = ld;
    hold       = h;
    flush      = f;
  endtask

  // Drive one ID cycle, compare combinational outputs on the falling edge, then clock it.
  task automatic step(input string tag, input logic v, input int rs0, input int rs1, input int rd,
                      input logic we, input logic ld, input logic h, input logic f,
                      input logic [3:0] sa, input bit ka, input logic sta, input int ca,
                      input logic [3:0] sb, input bit kb, input logic stb, input int cb);
    drive(v, rs0, rs1, rd, we, ld, h, f);
    push_exp(tag, sa, ka, sta, ca, sb, kb, stb, cb);
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step("in_reset",    1, 2, 3, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    rst_n = 1'b1;
    step("no_dep",      1, 2, 3, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("alu3_first",  1, 0, 0, 3, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("ex_fwd",      1, 2, 3, 3, 1, 0, 0, 0, 4'b1100, 1, 0, 0, 4'b1100, 1, 0, 0);
    step("ex_over_mem", 1, 3, 3, 0, 0, 0, 0, 0, 4'b1111, 1, 0, 0, 4'b1111, 1, 0, 0);
    step("mem_fwd",     1, 3, 3, 0, 0, 0, 0, 0, 4'b1010, 1, 0, 0, 4'b1010, 1, 0, 0);
    step("wb_fwd",      1, 3, 2, 0, 0, 0, 0, 0, SelWb0,  1, 0, 0, SelWb0,  1, 0, 0);
    step("write_x0",    1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("rs_zero",     1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("load5",       1, 0, 0, 5, 1, 1, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("luse5_c0",    1, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 0);
    step("luse5_c1",    1, 5, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 0, 1, 4'b0000, 0, 1, 1);
    step("luse5_c2",    1, 5, 0, 0, 0, 0, 0, 0, SelWb0,  1, 0, 1, SelWb0,  1, 0, 2);
    step("load7",       1, 0, 0, 7, 1, 1, 0, 0, 4'b0000, 1, 0, 1, 4'b0000, 1, 0, 2);
    step("hold_c0",     1, 0, 7, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 1, 4'b0000, 0, 1, 2);
    step("hold_c1",     1, 0, 7, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 1, 4'b0000, 0, 1, 2);
    step("flush",       1, 0, 7, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2);
    step("load9",       1, 0, 0, 9, 1, 1, 0, 0, 4'b0000, 1, 0, 1, 4'b0000, 1, 0, 2);

    // Load-use stall on rs=9, then an asynchronous reset between clock edges.
    drive(1, 9, 9, 0, 0, 0, 0, 0);
    push_exp("luse9", 4'b0000, 0, 1, 1, 4'b0000, 0, 1, 2);
    @(negedge clk);
    score();
    #2 rst_n = 1'b0;
    #1;
    push_exp("rst_async", 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    score();
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("post_rst",    1, 9, 9, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("load4_a",     1, 0, 0, 4, 1, 1, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 0);
    step("luse4_a0",    1, 4, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 0);
    step("luse4_a1",    1, 4, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 0, 1, 4'b0000, 0, 1, 1);
    step("luse4_a2",    1, 4, 0, 0, 0, 0, 0, 0, SelWb0,  1, 0, 1, SelWb0,  1, 0, 2);
    step("load4_b",     1, 0, 0, 4, 1, 1, 0, 0, 4'b0000, 1, 0, 1, 4'b0000, 1, 0, 2);
    step("luse4_b0",    1, 4, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'b0000, 0, 1, 2);
    step("luse4_b1",    1, 4, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 0, 2, 4'b0000, 0, 1, 3);
    step("cnt_sat",     1, 4, 0, 0, 0, 0, 0, 0, SelWb0,  1, 0, 2, SelWb0,  1, 0, 3);
    step("load6",       1, 0, 0, 6, 1, 1, 0, 0, 4'b0000, 1, 0, 2, 4'b0000, 1, 0, 3);
    step("id_invalid",  0, 6, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 2, 4'b0000, 0, 0, 3);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
